ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Sequences the instruction-bus fetch datapath: owns the fetch PC and issues one instruction request at a time.
- Captures each response and presents it to decode through a valid/ready handshake.
- Applies MIPS branch/jump redirects with delay-slot semantics; an exception flush kills the current fetch immediately.
- Sits between the ibus port and the decode stage, and drives the PC/instruction pair that decode consumes.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  out  1  instruction request valid
- ireq_addr  out  32  request address (always equals internal pc)
- ireq_ready  in  1  ibus accepts request this cycle
- iresp_valid  in  1  response data valid
- iresp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: taken branch/jump resolved in decode
- redirect_branch_pc  in  32  PC of the branch/jump instruction
- redirect_target  in  32  branch/jump target
- flush_valid  in  1  one-cycle exception flush
- flush_target  in  32  exception vector
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes this cycle
- out_pc  out  32  PC of presented instruction
- out_instr  out  32  presented instruction

Behaviour:
- Reset (async assert, clears immediately): state=IDLE, pc=RESET_PC, pending=0, kill=0, out_valid=0, ireq_valid=0, out_pc=0, out_instr=0.
- Single-outstanding rule: at most one instruction is in flight or held. No request issues while in WAIT or HOLD.
- IDLE: ireq_valid=0; go to REQ next cycle.
- REQ:
  - ireq_valid=1, ireq_addr=pc.
  - On ireq_ready: last_pc<=pc; pc<=pending ? pending_target : pc+4; pending<=0; go to WAIT.
  - ibus samples ireq_addr only on ready, so pc may change while ready is low (redirect/flush).
- WAIT:
  - On iresp_valid with kill=1: kill<=0, response dropped, go to REQ.
  - On iresp_valid with kill=0: out_instr<=iresp_data, out_pc<=last_pc, go to HOLD.
  - Minimum latency from acceptance to out_valid is 1 cycle after iresp_valid.
- HOLD: out_valid=1; out_pc and out_instr are stable until out_ready, then go to REQ.
- Redirect, evaluated at the redirect_valid pulse with d=redirect_branch_pc+4:
  - pc==d (delay slot not yet issued): pending<=1, pending_target<=redirect_target. The delay slot is fetched next, then the target.
  - pc==d+4 (delay slot already issued, held or in flight): pc<=redirect_target.
  - If the d+4 request is accepted in the same cycle, it is wrong-path: kill<=1, pc<=redirect_target.
  - Any other pc value is a protocol error (assertion). Redirect while pending=1 is a protocol error.
- Flush (highest priority; wins over redirect, ireq_ready and out_ready in the same cycle):
  - pc<=flush_target, pending<=0.
  - REQ: stay in REQ. If accepted the same cycle: kill<=1, go to WAIT.
  - WAIT: kill<=1, stay in WAIT.
  - HOLD: out_valid drops next cycle, instruction discarded (even if out_ready was high), go to REQ.
  - IDLE: go to REQ.
- Arithmetic: pc+4 is 32-bit wrap-around (0xFFFF_FFFC -> 0x0). Low two address bits pass through unchecked.
- iresp_valid in IDLE, REQ or HOLD is ignored. This covers late responses after reset.

Test Plan:
- Reset release, ireq_ready=1, iresp one cycle after accept, out_ready=1 -> ireq_addr 0x0,0x4,0x8; out_pc 0x0,0x4 with matching out_instr.
- Redirect (branch_pc=0x10, target=0x100) while REQ presents pc=0x14 -> accepted addrs 0x14 then 0x100; decode sees out_pc 0x14 then 0x100.
- Same redirect while in WAIT for 0x14 (pc=0x18) -> 0x14 delivered, next ireq_addr 0x100; 0x18 never requested.
- flush_valid in WAIT (target 0x80) -> response dropped, out_valid stays 0, next ireq_addr 0x80. Flush coincident with redirect -> 0x80.
- out_ready low 5 cycles in HOLD -> out_valid=1 with stable out_pc/out_instr, ireq_valid=0 throughout; release -> next request pc+4.
- Async reset asserted mid-WAIT, iresp_valid arrives after deassert -> outputs cleared same cycle, stale response ignored, first request at RESET_PC.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch sequencer.
// Owns the fetch PC, keeps at most one ibus request in flight or held,
// applies MIPS delay-slot redirects and exception flushes, and hands
// each fetched instruction to decode through a valid/ready handshake.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_branch_pc,
  input  logic [31:0] redirect_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_last_pc;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_pending;
  logic        r_kill;
  logic        r_out_valid;
  logic        r_ireq_valid;

  logic [31:0] w_ds;
  logic [31:0] w_after_ds;
  logic [31:0] w_pc_seq;
  logic        w_accept;
  logic        w_rd_ds;
  logic        w_rd_past;

  // d = delay-slot address; d+4 = first wrong-path address after it
  assign w_ds       = redirect_branch_pc + 32'd4;
  assign w_after_ds = w_ds + 32'd4;
  assign w_pc_seq   = r_pending ? r_pend_tgt : (r_pc + 32'd4);
  assign w_accept   = (r_state == S_REQ) && ireq_ready;
  // pc still at delay slot: it must be fetched first, target after
  assign w_rd_ds    = redirect_valid && (r_pc == w_ds);
  // delay slot already issued: pc now points at a wrong-path fetch
  assign w_rd_past  = redirect_valid && (r_pc == w_after_ds);

  assign ireq_valid = r_ireq_valid;
  assign ireq_addr  = r_pc;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;

  // Fetch FSM: PC/redirect bookkeeping plus request/response/hand-off sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_last_pc    <= 32'h0;
      r_pend_tgt   <= 32'h0;
      r_pending    <= 1'b0;
      r_kill       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_ireq_valid <= 1'b0;
      r_out_pc     <= 32'h0;
      r_out_instr  <= 32'h0;
    end else if (flush_valid) begin
      // Flush overrides redirect and both handshakes this cycle
      r_pc      <= flush_target;
      r_pending <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
        S_REQ: begin
          if (ireq_ready) begin
            // ibus took the old address; its response must be dropped
            r_last_pc    <= r_pc;
            r_kill       <= 1'b1;
            r_state      <= S_WAIT;
            r_ireq_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            // response landing on the flush cycle is dropped right here
            r_kill       <= 1'b0;
            r_state      <= S_REQ;
            r_ireq_valid <= 1'b1;
          end else begin
            r_kill <= 1'b1;
          end
        end
        default: begin
          r_out_valid  <= 1'b0;
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
      endcase
    end else begin
      if (w_accept) begin
        r_last_pc <= r_pc;
        r_pending <= 1'b0;
        if (w_rd_ds) begin
          // the delay slot goes out now, so the target is next
          r_pc <= redirect_target;
        end else if (w_rd_past) begin
          // wrong-path address accepted this very cycle
          r_pc   <= redirect_target;
          r_kill <= 1'b1;
        end else begin
          r_pc <= w_pc_seq;
        end
      end else if (w_rd_ds) begin
        r_pending  <= 1'b1;
        r_pend_tgt <= redirect_target;
      end else if (w_rd_past) begin
        r_pc <= redirect_target;
      end

      case (r_state)
        S_IDLE: begin
          r_state      <= S_REQ;
          r_ireq_valid <= 1'b1;
        end
        S_REQ: begin
          if (ireq_ready) begin
            r_state      <= S_WAIT;
            r_ireq_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            if (r_kill) begin
              r_kill       <= 1'b0;
              r_state      <= S_REQ;
              r_ireq_valid <= 1'b1;
            end else begin
              r_out_instr <= iresp_data;
              r_out_pc    <= r_last_pc;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        default: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_state      <= S_REQ;
            r_ireq_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  // Decode must redirect only from the delay slot or the address after it
  always @(posedge clk) begin
    if (!reset && redirect_valid && !flush_valid)
      assert (!r_pending && (w_rd_ds || w_rd_past))
        else $error("ifetch_ctrl: redirect protocol error pc=%h branch_pc=%h", r_pc, redirect_branch_pc);
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: an ibus responder with programmable
// latency logs accepted addresses and decode hand-offs; directed tests
// compare those logs and sampled outputs against hand-computed values.
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready = 1'b0;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_branch_pc = 32'h0;
  logic [31:0] redirect_target = 32'h0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_target = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_branch_pc(redirect_branch_pc),
    .redirect_target(redirect_target),
    .flush_valid(flush_valid), .flush_target(flush_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] acc_q[$];
  logic [31:0] dpc_q[$];
  logic [31:0] dins_q[$];
  int          rsp_lat = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'h0;
  logic        keep_stale = 1'b0;
  int          ba, bd, c18;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ibus model + logger, evaluated 2ns after each negedge once inputs settle
  always @(negedge clk) begin
    #2;
    if (reset && !keep_stale) rsp_cnt = 0;
    iresp_valid = 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        iresp_valid = 1'b1;
        iresp_data  = mem(rsp_addr);
      end
    end
    if (ireq_valid && ireq_ready) begin
      acc_q.push_back(ireq_addr);
      rsp_addr = ireq_addr;
      rsp_cnt  = rsp_lat;
    end
    if (out_valid && out_ready) begin
      dpc_q.push_back(out_pc);
      dins_q.push_back(out_instr);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    flush_valid = 1'b0;
    ireq_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int k;
    k = 0;
    while (!(ireq_valid && ireq_addr == a) && k < 60) begin
      tick();
      k++;
    end
    chk(tag, 32'(ireq_valid && ireq_addr == a), 1);
  endtask

  initial begin
    // ---- reset state and basic sequential fetch ----
    ireq_ready = 1'b1;
    out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_ireq_valid", 32'(ireq_valid), 0);
    chk("rst_ireq_addr", ireq_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    reset = 1'b0;
    chk("idle_no_req", 32'(ireq_valid), 0);
    ba = acc_q.size();
    bd = dpc_q.size();
    tick();
    chk("t1_req_valid", 32'(ireq_valid), 1);
    chk("t1_req_addr", ireq_addr, 32'h0);
    tick();
    chk("t1_wait_outv", 32'(out_valid), 0);
    tick();
    chk("t1_lat_outv", 32'(out_valid), 1);
    chk("t1_lat_pc", out_pc, 32'h0);
    chk("t1_lat_instr", out_instr, mem(32'h0));
    repeat (6) tick();
    chk("t1_acc0", acc_q[ba], 32'h0);
    chk("t1_acc1", acc_q[ba+1], 32'h4);
    chk("t1_acc2", acc_q[ba+2], 32'h8);
    chk("t1_del0", dpc_q[bd], 32'h0);
    chk("t1_del1", dpc_q[bd+1], 32'h4);
    chk("t1_ins1", dins_q[bd+1], mem(32'h4));

    // ---- redirect while REQ presents the delay slot (pending path) ----
    do_reset();
    wait_req("t2_reach14", 32'h14);
    ba = acc_q.size();
    bd = dpc_q.size();
    ireq_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_branch_pc = 32'h10;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    ireq_ready = 1'b1;
    chk("t2_still14", ireq_addr, 32'h14);
    repeat (12) tick();
    chk("t2_acc0", acc_q[ba], 32'h14);
    chk("t2_acc1", acc_q[ba+1], 32'h100);
    chk("t2_del0", dpc_q[bd], 32'h14);
    chk("t2_del1", dpc_q[bd+1], 32'h100);
    chk("t2_ins1", dins_q[bd+1], mem(32'h100));

    // ---- redirect while WAIT for the delay slot (pc already d+4) ----
    do_reset();
    wait_req("t3_reach14", 32'h14);
    ba = acc_q.size();
    bd = dpc_q.size();
    tick();
    chk("t3_wait_noreq", 32'(ireq_valid), 0);
    chk("t3_pc18", ireq_addr, 32'h18);
    redirect_valid = 1'b1;
    redirect_branch_pc = 32'h10;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    chk("t3_acc0", acc_q[ba], 32'h14);
    chk("t3_acc1", acc_q[ba+1], 32'h100);
    chk("t3_del0", dpc_q[bd], 32'h14);
    chk("t3_del1", dpc_q[bd+1], 32'h100);
    c18 = 0;
    for (int i = ba; i < acc_q.size(); i++)
      if (acc_q[i] == 32'h18) c18++;
    chk("t3_no18", c18, 0);

    // ---- flush during WAIT, late response must be dropped ----
    do_reset();
    rsp_lat = 2;
    wait_req("t4_reach8", 32'h8);
    tick();
    ba = acc_q.size();
    bd = dpc_q.size();
    flush_valid = 1'b1;
    flush_target = 32'h80;
    chk("t4_outv_a", 32'(out_valid), 0);
    tick();
    flush_valid = 1'b0;
    chk("t4_outv_b", 32'(out_valid), 0);
    tick();
    chk("t4_outv_c", 32'(out_valid), 0);
    chk("t4_req_v", 32'(ireq_valid), 1);
    chk("t4_req_a", ireq_addr, 32'h80);
    repeat (12) tick();
    chk("t4_acc0", acc_q[ba], 32'h80);
    chk("t4_del0", dpc_q[bd], 32'h80);
    chk("t4_ins0", dins_q[bd], mem(32'h80));
    rsp_lat = 1;

    // ---- flush coincident with redirect: flush wins, pending cleared ----
    do_reset();
    wait_req("t4b_reach14", 32'h14);
    ba = acc_q.size();
    ireq_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_branch_pc = 32'h10;
    redirect_target = 32'h100;
    flush_valid = 1'b1;
    flush_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    flush_valid = 1'b0;
    ireq_ready = 1'b1;
    chk("t4b_addr", ireq_addr, 32'h80);
    repeat (10) tick();
    chk("t4b_acc0", acc_q[ba], 32'h80);
    chk("t4b_acc1", acc_q[ba+1], 32'h84);

    // ---- decode back-pressure in HOLD ----
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("t5_hold", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_outv", 32'(out_valid), 1);
      chk("t5_pc", out_pc, 32'h0);
      chk("t5_ins", out_instr, mem(32'h0));
      chk("t5_noreq", 32'(ireq_valid), 0);
    end
    ba = acc_q.size();
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t5_next", acc_q[ba], 32'h4);

    // ---- async reset mid-WAIT, stale response after release ----
    do_reset();
    rsp_lat = 3;
    keep_stale = 1'b1;
    wait_req("t6_reach4", 32'h4);
    tick();
    #1 reset = 1'b1;
    #1;
    chk("t6_ireqv", 32'(ireq_valid), 0);
    chk("t6_addr", ireq_addr, 32'h0);
    chk("t6_outv", 32'(out_valid), 0);
    chk("t6_ins", out_instr, 32'h0);
    tick();
    reset = 1'b0;
    ba = acc_q.size();
    bd = dpc_q.size();
    repeat (10) tick();
    chk("t6_acc0", acc_q[ba], 32'h0);
    chk("t6_del0", dpc_q[bd], 32'h0);
    chk("t6_ins0", dins_q[bd], mem(32'h0));
    keep_stale = 1'b0;
    rsp_lat = 1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
